// File: rtl/word_block_buffer_if.sv
// Handshake bundle between the word block buffer, its upstream word source and its downstream consumer.
interface word_block_buffer_if #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
);
    logic                     wr_en;
    logic                     wr_last;
    logic [WIDTH-1:0]         wr_data;
    logic                     wr_ready;
    logic                     rd_valid;
    logic                     rd_ready;
    logic [WIDTH-1:0]         rd_data;
    logic [$clog2(DEPTH)-1:0] rd_index;
    logic                     rd_last;

    // Source/consumer side: drives writes and read acceptance.
    modport master (
        output wr_en, wr_last, wr_data, rd_ready,
        input  wr_ready, rd_valid, rd_data, rd_index, rd_last
    );

    // Buffer side.
    modport slave (
        input  wr_en, wr_last, wr_data, rd_ready,
        output wr_ready, rd_valid, rd_data, rd_index, rd_last
    );
endinterface

// File: rtl/word_block_buffer.sv
// Gathers words into a DEPTH-word block, zero-pads short blocks, then drains them over valid/ready.
// Optional WB_WORD_COUNT_EN: the last pad word of a short block carries the message word count.
module word_block_buffer #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    word_block_buffer_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        PAD   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     wptr_q, wptr_d;
    logic [AW-1:0]     rptr_q, rptr_d;
    logic [WIDTH-1:0]  mem_q [DEPTH];

    logic              mem_we;
    logic [WIDTH-1:0]  mem_wdata;
    logic [WIDTH-1:0]  pad_word;
    logic              wr_ready;
    logic              rd_valid;

`ifdef WB_WORD_COUNT_EN
    logic [AW:0]       cnt_q;

    // Count of message words in a short block, latched on the wr_last that starts padding.
    always_ff @(posedge clk) begin
        if (state_q == FILL && bus.wr_en && bus.wr_last && wptr_q != LAST_IDX) begin
            cnt_q <= {1'b0, wptr_q} + (AW+1)'(1);
        end
    end

    assign pad_word = (wptr_q == LAST_IDX) ? WIDTH'(cnt_q) : '0;
`else
    assign pad_word = '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FILL;
            wptr_q  <= '0;
            rptr_q  <= '0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
        end
    end

    // Writes are suppressed while reset is held.
    always_ff @(posedge clk) begin
        if (rst_n && mem_we) begin
            mem_q[wptr_q] <= mem_wdata;
        end
    end

    always_comb begin
        state_d   = state_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        mem_we    = 1'b0;
        mem_wdata = '0;
        wr_ready  = 1'b0;
        rd_valid  = 1'b0;

        unique case (state_q)
            FILL: begin
                wr_ready = 1'b1;
                if (bus.wr_en) begin
                    mem_we    = 1'b1;
                    mem_wdata = bus.wr_data;
                    wptr_d    = wptr_q + AW'(1);
                    if (wptr_q == LAST_IDX) begin
                        state_d = DRAIN;
                    end else if (bus.wr_last) begin
                        state_d = PAD;
                    end
                end
            end
            PAD: begin
                mem_we    = 1'b1;
                mem_wdata = pad_word;
                wptr_d    = wptr_q + AW'(1);
                if (wptr_q == LAST_IDX) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                rd_valid = 1'b1;
                if (bus.rd_ready) begin
                    rptr_d = rptr_q + AW'(1);
                    if (rptr_q == LAST_IDX) begin
                        state_d = FILL;
                        wptr_d  = '0;
                        rptr_d  = '0;
                    end
                end
            end
            default: begin
                state_d = FILL;
                wptr_d  = '0;
                rptr_d  = '0;
            end
        endcase
    end

    assign bus.wr_ready = wr_ready;
    assign bus.rd_valid = rd_valid;
    assign bus.rd_data  = rd_valid ? mem_q[rptr_q] : '0;
    assign bus.rd_index = rptr_q;
    assign bus.rd_last  = rd_valid && (rptr_q == LAST_IDX);

endmodule

// File: doc/word_block_buffer.md
# word_block_buffer

Collects 32-bit words emitted by the byte-to-word shift register into a fixed block of DEPTH words, zero-pads a short final block, then drains the block word-by-word to the downstream consumer over a valid/ready handshake. It sits directly downstream of the shift register. It receives one word per pulse of that stage's `full` flag, plus a message-end marker driven by the control unit.

## Interface
- `DEPTH`, 16: words per block; power of two, at least 4.
- `WIDTH`, 32: word width.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `wr_en`  in  1  `wr_data` is valid this cycle. Connected to the upstream `full`.
- `wr_last`  in  1  qualifies `wr_en`: this word is the final word of the message.
- `wr_data`  in  WIDTH  incoming word.
- `wr_ready`  out  1  block accepts a word this cycle.
- `rd_valid`  out  1  `rd_data` holds a block word.
- `rd_ready`  in  1  consumer takes `rd_data` this cycle.
- `rd_data`  out  WIDTH  current block word. Forced to 0 when `rd_valid`=0.
- `rd_index`  out  log2(DEPTH)  index of `rd_data` within the block.
- `rd_last`  out  1  high with `rd_valid` when `rd_index`=DEPTH-1.

## Operation
- Storage is a DEPTH×WIDTH register array. Pointers: `wptr` and `rptr`, each log2(DEPTH) bits wide.
- Reset and initial state:
  - Reset sets state to FILL and sets `wptr` and `rptr` to 0.
  - Array contents are not cleared.
  - While `rst_n`=0, all writes are ignored.
- FILL state:
  - `wr_ready`=1 and `rd_valid`=0.
  - On `wr_en`, `mem[wptr]`←`wr_data`.
  - If `wptr`=DEPTH-1, go to DRAIN. `wr_last` is irrelevant in this case.
  - Else if `wr_last`=1, increment `wptr` and go to PAD.
  - Otherwise, increment `wptr`.
- PAD state:
  - `wr_ready`=0.
  - Each cycle, `mem[wptr]`←0 and `wptr` increments.
  - After writing index DEPTH-1, go to DRAIN.
- DRAIN state:
  - `wr_ready`=0 and `rd_valid`=1.
  - `rd_data`=`mem[rptr]` and `rd_index`=`rptr`.
  - On `rd_ready`, increment `rptr`.
  - When `rd_ready` is seen with `rptr`=DEPTH-1, return to FILL with `wptr`=`rptr`=0.
- `wr_en` outside FILL is ignored (no write, no pointer change). Upstream must hold off using `wr_ready`.
- Pointer wrap: the DEPTH-1→0 transition happens only on the block boundary.

## Timing
- A word written on edge N in FILL becomes readable no earlier than the DRAIN entry.
- Full block: DRAIN is entered on the edge that writes the DEPTH-th word. `rd_valid`=1 in the following cycle.
- Short block: `wr_last` at `wptr`=k gives DEPTH-1-k PAD cycles, then DRAIN.
- Drain throughput: one word per cycle while `rd_ready`=1. Holding `rd_ready`=0 holds `rd_data` and `rd_index` stable.
- FILL is re-entered the cycle after the final handshake, with `wr_ready`=1. There is no bubble beyond that cycle.
- Reset mid-PAD or mid-DRAIN:
  - Block is abandoned; next cycle is FILL with pointers at 0.
  - `rd_valid` drops in the cycle after the reset edge.

## Configuration
- `WB_WORD_COUNT_EN` defined:
  - In a padded block, index DEPTH-1 receives the count of message words in that block, zero-extended to WIDTH, instead of 0.
  - The count is k+1 for `wr_last` at `wptr`=k, where k ≤ DEPTH-2.
  - Full blocks are unchanged.
- `WB_WORD_COUNT_EN` undefined: all pad words are 0.

## Test plan
- 16 words 0x00000001..0x00000010 written, `wr_last` only on the 16th, `rd_ready`=1 → no PAD cycles; `rd_data` 0x1..0x10 on consecutive cycles; `rd_last` with 0x10; `wr_ready`=1 the next cycle.
- 5 words 0xA0..0xA4, `wr_last` on 0xA4 → 11 PAD cycles; drain shows 0xA0..0xA4 then eleven 0x0. With the macro defined, index 15 = 0x00000005.
- Drain with `rd_ready` toggling 1,0,0,1,… → every index 0..15 delivered exactly once, in order; `rd_data` stable while stalled.
- `wr_en`=1 with 0xDEAD throughout PAD and DRAIN → no array change and no pointer change; next block starts at index 0.
- `rst_n`=0 for one cycle at `rd_index`=7 → next cycle FILL, `rd_valid`=0, `rd_data`=0, `wr_ready`=1; a new 16-word block drains correctly.
- `wr_last` on the very first word 0x12345678 → drain 0x12345678 then 15 words of 0. With the macro defined, the last word is 0x00000001.
